// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS control path.
// The aluop encodings are also consumed by the downstream ALU decoder.
package mips_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StRtypeEx,
    StAluWb,
    StBeqEx,
    StAddiEx,
    StAddiWb,
    StJEx
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: is_legal_op = 1'b1;
      default:                                        is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_maindec_if.sv
// Datapath/memory side of the main controller: opcode and memory handshake in,
// control word and retired-instruction count out.
interface mc_maindec_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       op;
  logic             mem_ready;
  logic             irwrite;
  logic             pcwrite;
  logic             branch;
  logic             iord;
  logic             memwrite;
  logic             regdst;
  logic             memtoreg;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       pcsrc;
  logic [1:0]       aluop;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  op, mem_ready,
    output irwrite, pcwrite, branch, iord, memwrite, regdst, memtoreg, regwrite,
    output alusrca, alusrcb, pcsrc, aluop, illegal_op, instr_count
  );

  modport slave (
    output op, mem_ready,
    input  irwrite, pcwrite, branch, iord, memwrite, regdst, memtoreg, regwrite,
    input  alusrca, alusrcb, pcsrc, aluop, illegal_op, instr_count
  );
endinterface

// File: rtl/retire_cnt.sv
// Retired-instruction counter; wraps modulo 2^CNT_W.
module retire_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and counts retired instructions.
module mc_maindec
  import mips_pkg::*;
#(
  parameter bit          USE_MEM_READY = 1'b1,
  parameter int unsigned CNT_W         = 32
) (
  input logic           clk,
  input logic           reset,
  mc_maindec_if.master  bus
);
  state_t state_q, state_d;
  ctrl_t  ctrl_raw, ctrl;
  logic   mem_rdy;
  logic   legal_op;
  logic   retire;

  assign mem_rdy  = USE_MEM_READY ? bus.mem_ready : 1'b1;
  assign legal_op = is_legal_op(bus.op);

  always_ff @(posedge clk) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      StFetch:   if (mem_rdy) state_d = StDecode;
      StDecode: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StRtypeEx;
          OP_BEQ:       state_d = StBeqEx;
          OP_ADDI:      state_d = StAddiEx;
          OP_J:         state_d = StJEx;
          default:      state_d = StFetch;
        endcase
      end
      StMemAdr:  state_d = (bus.op == OP_SW) ? StMemWr :
                           (bus.op == OP_LW) ? StMemRd : StFetch;
      StMemRd:   if (mem_rdy) state_d = StMemWb;
      StMemWr: begin
        if (mem_rdy) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StRtypeEx: state_d = StAluWb;
      StAddiEx:  state_d = StAddiWb;
      StMemWb, StAluWb, StBeqEx, StAddiWb, StJEx: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      default:   state_d = StFetch;
    endcase
  end

  // Raw per-state control word; Mealy terms and reset override are applied afterwards.
  always_comb begin
    ctrl_raw = CTRL_IDLE;
    unique case (state_q)
      StFetch: begin
        ctrl_raw.irwrite = 1'b1;
        ctrl_raw.pcwrite = 1'b1;
        ctrl_raw.alusrcb = SRCB_FOUR;
        ctrl_raw.aluop   = ALUOP_ADD;
      end
      StDecode: begin
        ctrl_raw.alusrcb = SRCB_IMMSH;
        ctrl_raw.aluop   = ALUOP_ADD;
      end
      StMemAdr, StAddiEx: begin
        ctrl_raw.alusrca = 1'b1;
        ctrl_raw.alusrcb = SRCB_IMM;
        ctrl_raw.aluop   = ALUOP_ADD;
      end
      StMemRd:   ctrl_raw.iord = 1'b1;
      StMemWr: begin
        ctrl_raw.iord     = 1'b1;
        ctrl_raw.memwrite = 1'b1;
      end
      StMemWb: begin
        ctrl_raw.memtoreg = 1'b1;
        ctrl_raw.regwrite = 1'b1;
      end
      StRtypeEx: begin
        ctrl_raw.alusrca = 1'b1;
        ctrl_raw.alusrcb = SRCB_REG;
        ctrl_raw.aluop   = ALUOP_FUNCT;
      end
      StAluWb: begin
        ctrl_raw.regdst   = 1'b1;
        ctrl_raw.regwrite = 1'b1;
      end
      StBeqEx: begin
        ctrl_raw.alusrca = 1'b1;
        ctrl_raw.alusrcb = SRCB_REG;
        ctrl_raw.aluop   = ALUOP_SUB;
        ctrl_raw.pcsrc   = PCSRC_ALUOUT;
        ctrl_raw.branch  = 1'b1;
      end
      StAddiWb:  ctrl_raw.regwrite = 1'b1;
      StJEx: begin
        ctrl_raw.pcsrc   = PCSRC_JUMP;
        ctrl_raw.pcwrite = 1'b1;
      end
      default:   ctrl_raw = CTRL_IDLE;
    endcase
  end

  always_comb begin
    ctrl = ctrl_raw;
    if (state_q == StFetch) begin
      ctrl.irwrite = mem_rdy;
      ctrl.pcwrite = mem_rdy;
    end
    ctrl.illegal_op = (state_q == StDecode) && !legal_op;
    if (reset) begin
      ctrl         = CTRL_IDLE;
      ctrl.alusrcb = SRCB_FOUR;
      ctrl.aluop   = ALUOP_ADD;
      ctrl.pcsrc   = PCSRC_ALU;
    end
  end

  assign bus.irwrite    = ctrl.irwrite;
  assign bus.pcwrite    = ctrl.pcwrite;
  assign bus.branch     = ctrl.branch;
  assign bus.iord       = ctrl.iord;
  assign bus.memwrite   = ctrl.memwrite;
  assign bus.regdst     = ctrl.regdst;
  assign bus.memtoreg   = ctrl.memtoreg;
  assign bus.regwrite   = ctrl.regwrite;
  assign bus.alusrca    = ctrl.alusrca;
  assign bus.alusrcb    = ctrl.alusrcb;
  assign bus.pcsrc      = ctrl.pcsrc;
  assign bus.aluop      = ctrl.aluop;
  assign bus.illegal_op = ctrl.illegal_op;

  retire_cnt #(
    .CNT_W (CNT_W)
  ) u_retire_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (retire),
    .count (bus.instr_count)
  );
endmodule
